seq_comparator: RTL and testbench
=================================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits compared per clock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin a comparison.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port busy, output, 1 bit: a comparison is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-010 SHALL have port f1, output, 1 bit: result A > B.
REQ-011 SHALL have port f2, output, 1 bit: result A < B.
REQ-012 SHALL have port f3, output, 1 bit: result A == B.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CMP, DONE.
REQ-014 SHALL, on a rising edge with start=1 in IDLE or DONE, capture a and b into internal registers, clear the chunk index, and enter CMP.
REQ-015 SHALL ignore start while in CMP: captured operands and the comparison in progress are unaffected.
REQ-016 SHALL, in CMP, compare one CHUNK-bit slice per edge, starting from the MSB slice and moving toward the LSB.
REQ-017 SHALL, when the current slices differ, load f1/f2 from that slice (unsigned compare), set f3=0, and enter DONE on that edge (early exit).
REQ-018 SHALL, when the last (LSB) slice is equal, set f3=1, f1=0, f2=0 and enter DONE.
REQ-019 SHALL assert done during DONE only, for exactly one cycle per comparison, k edges after the start-sampling edge, where k is the 1-based index of the deciding slice (k <= WIDTH/CHUNK).
REQ-020 SHALL assert busy exactly while in CMP.
REQ-021 SHALL leave DONE for IDLE when start=0; if start=1 in DONE, a new capture occurs per REQ-014 and done still pulses in that cycle.
REQ-022 SHALL hold f1/f2/f3 stable from one comparison result until the next one; after the first result, exactly one of f1/f2/f3 is high.
REQ-023 SHALL treat WIDTH % CHUNK != 0, or CHUNK < 1, as an elaboration-time error.
REQ-024 SHALL size the slice index as $clog2(WIDTH/CHUNK), with a minimum of 1 bit.

Reset
REQ-025 SHALL, while rst_n=0 (asynchronously, including mid-CMP), force: state=IDLE, busy=0, done=0, f1=f2=f3=0, captured operands and chunk index=0.
REQ-026 SHALL not produce a done pulse for any comparison aborted by reset; the first edge after rst_n rises may accept start.

Configuration
REQ-027 SHALL, when SEQ_COMPARATOR_SIGNED_EN is defined, add input signed_mode (1 bit), sampled at start together with the operands.
REQ-028 SHALL, when signed_mode=1 was captured, compare the operands as two's complement by inverting the MSB of both operands in the MSB slice compare only; latency is unchanged.
REQ-029 SHALL, when SEQ_COMPARATOR_SIGNED_EN is undefined, have no signed_mode port and perform an unsigned compare only.

Verification
REQ-030 SHALL cover, at WIDTH=16 and CHUNK=4: a=0x1234, b=0x1234 -> f3=1, done 4 edges after start, busy high for 4 cycles.
REQ-031 SHALL cover: a=0xF000, b=0x0FFF -> f1=1, done 1 edge after start; then a=0x1230, b=0x1231 -> f2=1, done 4 edges after start.
REQ-032 SHALL cover: start a=0x0001, b=0x0002, then pulse start with a=0xFFFF, b=0x0000 during CMP -> the second request is ignored and f2=1.
REQ-033 SHALL cover: rst_n low for 1 cycle mid-CMP -> busy, done and f1/f2/f3 go to 0 immediately; no done follows; the next start completes normally.
REQ-034 SHALL cover, with SEQ_COMPARATOR_SIGNED_EN defined: a=0x8000, b=0x0001 -> f2=1 with signed_mode=1 and f1=1 with signed_mode=0.
REQ-035 SHALL cover, at WIDTH=4 and CHUNK=1: all 256 (a, b) pairs back-to-back, with start asserted in DONE -> each result matches >, < and == and each done latency is <= 4.

Source files
------------

// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: walks the operands CHUNK bits per clock from the MSB slice.
// Optional two's-complement mode is enabled with `define SEQ_COMPARATOR_SIGNED_EN.
//
//   state  | meaning
//   IDLE   | waiting for start
//   CMP    | comparing slice idx_q (0 = MSB slice)
//   DONE   | result valid, done pulse; start here begins the next compare
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             f1,
  output logic             f2,
  output logic             f3
);

  localparam int CW     = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NSLICE = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_comparator: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_comparator: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    a_sl, b_sl;
  logic             last_sl;

  // State register and captured datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      f3_q    <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      f3_q    <= f3_d;
      sgn_q   <= sgn_d;
    end
  end

  // Current slice pair; in signed mode the sign bit is flipped in the MSB slice only
  always_comb begin
    a_sl    = CW'(a_q >> (CW * (NSLICE - 1 - int'(idx_q))));
    b_sl    = CW'(b_q >> (CW * (NSLICE - 1 - int'(idx_q))));
    if (sgn_q && (idx_q == '0)) begin
      a_sl[CW-1] = ~a_sl[CW-1];
      b_sl[CW-1] = ~b_sl[CW-1];
    end
    last_sl = (idx_q == IDX_W'(NSLICE - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    f3_d    = f3_q;
    sgn_d   = sgn_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
`ifdef SEQ_COMPARATOR_SIGNED_EN
          sgn_d   = signed_mode;
`else
          sgn_d   = 1'b0;
`endif
          state_d = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (a_sl != b_sl) begin
          f1_d    = (a_sl > b_sl);
          f2_d    = (a_sl < b_sl);
          f3_d    = 1'b0;
          state_d = S_DONE;
        end else if (last_sl) begin
          f1_d    = 1'b0;
          f2_d    = 1'b0;
          f3_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CMP);
    done = (state_q == S_DONE);
    f1   = f1_q;
    f2   = f2_q;
    f3   = f3_q;
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: a 16/4 instance for directed cases and a 4/1 instance
// swept over all operand pairs. Signed cases run when SEQ_COMPARATOR_SIGNED_EN is defined.
module tb_seq_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start4;
  logic [15:0] a16, b16;
  logic [3:0]  a4, b4;
  logic        sm16;
  logic        busy16, done16, f1_16, f2_16, f3_16;
  logic        busy4, done4, f1_4, f2_4, f3_4;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
`ifdef SEQ_COMPARATOR_SIGNED_EN
    .signed_mode(sm16),
`endif
    .busy(busy16), .done(done16), .f1(f1_16), .f2(f2_16), .f3(f3_16)
  );

  seq_comparator #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
`ifdef SEQ_COMPARATOR_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .busy(busy4), .done(done4), .f1(f1_4), .f2(f2_4), .f3(f3_4)
  );

  typedef struct {
    logic [2:0] f;
    int         cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse; {f1,f2,f3} and the cycle of the pulse
  always @(negedge clk) begin
    exp_t e;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_unexpected: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = q16.pop_front();
        chk("flags16", 32'({f1_16, f2_16, f3_16}), 32'(e.f));
        chk("latency16", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = q4.pop_front();
        chk("flags4", 32'({f1_4, f2_4, f3_4}), 32'(e.f));
        chk("latency4", cyc, e.cyc);
      end
    end
  end

  // Wait at negedges until done16, bounded; returns the busy cycles seen on the way
  task automatic wait_done16(output int busy_cnt);
    int guard;
    busy_cnt = 0;
    guard    = 0;
    while (done16 !== 1'b1 && guard < 40) begin
      if (busy16 === 1'b1) busy_cnt++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout16: got no done in %0d cycles expected done", guard);
    end
  endtask

  // Called at a negedge; leaves at the negedge where done16 is high
  task automatic go16(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] f,
                      input int k, output int busy_cnt);
    a16     = av;
    b16     = bv;
    start16 = 1'b1;
    q16.push_back('{f, cyc + 1 + k});
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(busy_cnt);
  endtask

  initial begin
    int bc;
    rst_n   = 1'b0;
    start16 = 1'b0;
    start4  = 1'b0;
    a16     = '0;
    b16     = '0;
    a4      = '0;
    b4      = '0;
    sm16    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_flags", 32'({f1_16, f2_16, f3_16}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    go16(16'h1234, 16'h1234, 3'b001, 4, bc);
    chk("busy_cycles_eq", bc, 4);
    @(negedge clk);
    go16(16'hF000, 16'h0FFF, 3'b100, 1, bc);
    chk("busy_cycles_msb", bc, 1);
    go16(16'h1230, 16'h1231, 3'b010, 4, bc);   // issued from DONE
    chk("busy_cycles_lsb", bc, 4);
    go16(16'h1300, 16'h1200, 3'b100, 2, bc);
    chk("busy_cycles_k2", bc, 2);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("flags_held", 32'({f1_16, f2_16, f3_16}), 32'(3'b100));

    // start during CMP must not disturb the compare in flight
    a16     = 16'h0001;
    b16     = 16'h0002;
    start16 = 1'b1;
    q16.push_back('{3'b010, cyc + 5});
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    a16     = 16'hFFFF;
    b16     = 16'h0000;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    a16     = 16'h0000;
    wait_done16(bc);
    repeat (4) @(negedge clk);

    // reset in the middle of a compare
    a16     = 16'h1111;
    b16     = 16'h1112;
    start16 = 1'b1;
    q16.push_back('{3'b010, cyc + 5});
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    chk("busy_before_rst", 32'(busy16), 1);
    chk("flags_before_rst", 32'({f1_16, f2_16, f3_16}), 32'(3'b010));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy16), 0);
    chk("abort_done", 32'(done16), 0);
    chk("abort_flags", 32'({f1_16, f2_16, f3_16}), 0);
    void'(q16.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle_busy", 32'(busy16), 0);
    go16(16'hABCD, 16'hABCE, 3'b010, 4, bc);
    @(negedge clk);

    go16(16'h8000, 16'h0001, 3'b100, 1, bc);
    @(negedge clk);
`ifdef SEQ_COMPARATOR_SIGNED_EN
    sm16 = 1'b1;
    go16(16'h8000, 16'h0001, 3'b010, 1, bc);
    sm16 = 1'b0;
    go16(16'h8000, 16'h0001, 3'b100, 1, bc);
    @(negedge clk);
`endif

    // Exhaustive 4-bit sweep, each start issued in the DONE cycle of the previous compare
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        logic [3:0] av, bv;
        logic [2:0] f;
        int         k;
        int         guard;
        bit         found;
        av    = 4'(ai);
        bv    = 4'(bi);
        f     = {av > bv, av < bv, av == bv};
        k     = 4;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
          if (!found && av[i] != bv[i]) begin
            k     = 4 - i;
            found = 1'b1;
          end
        end
        a4     = av;
        b4     = bv;
        start4 = 1'b1;
        q4.push_back('{f, cyc + 1 + k});
        @(negedge clk);
        start4 = 1'b0;
        guard  = 0;
        while (done4 !== 1'b1 && guard < 10) begin
          guard++;
          @(negedge clk);
        end
        if (guard >= 10) begin
          checks++;
          errors++;
          $display("FAIL timeout4: got no done for a=%0d b=%0d expected done", ai, bi);
        end
      end
    end
    @(negedge clk);
    repeat (4) @(negedge clk);

    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
